// File: rtl/mem_control_fsm.sv
// mem_control_fsm: multi-cycle controller sequencing fetch, decode, memory and stack traffic for the PC/SP/memory datapath
module mem_control_fsm #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] inst,
  input  logic        comp_true,
  output logic        MemWrite,
  output logic [1:0]  MemSrc,
  output logic [2:0]  MemDst,
  output logic [2:0]  PCSrc,
  output logic [2:0]  SPSrc,
  output logic        PCWrite,
  output logic        SPWrite,
  output logic        InstWrite,
  output logic        RegWrite,
  output logic [1:0]  RegWSel,
  output logic        AluWrite,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMRD  = 3'd3,
    MEMWR  = 3'd4,
    WB     = 3'd5,
    SPADJ  = 3'd6,
    HALT   = 3'd7
  } state_t;
  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);
  state_t cur, nxt;
  logic [3:0] wcnt;
  logic [3:0] op;
  logic mem_st, last, bad_op;
  logic unused_inst;
  assign op          = inst[15:12];
  assign unused_inst = ^inst[11:0];
  assign mem_st      = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  assign last        = wcnt == WAIT_MAX;
  assign bad_op      = (op >= 4'd9) && (op <= 4'd14);
  // state register and wait counter; the counter restarts on every state change
  always_ff @(posedge clock) begin
    if (!reset) begin
      cur  <= FETCH;
      wcnt <= 4'd0;
    end else begin
      cur  <= nxt;
      wcnt <= (nxt != cur) ? 4'd0 : (mem_st && !last) ? wcnt + 4'd1 : wcnt;
    end
  end
  // next-state selection; memory states hold until the final wait count
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = last ? DECODE : FETCH;
      DECODE: begin
        case (op)
          4'd0, 4'd5, 4'd6, 4'd7, 4'd8: nxt = EXEC;
          4'd1, 4'd4:                   nxt = MEMRD;
          4'd2:                         nxt = MEMWR;
          4'd3:                         nxt = SPADJ;
          4'd15:                        nxt = HALT;
          default:                      nxt = FETCH;
        endcase
      end
      EXEC:   nxt = FETCH;
      MEMRD:  nxt = last ? WB : MEMRD;
      MEMWR:  nxt = last ? FETCH : MEMWR;
      WB:     nxt = (op == 4'd4) ? SPADJ : FETCH;
      SPADJ:  nxt = (op == 4'd3) ? MEMWR : FETCH;
      HALT:   nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
  // datapath controls; a low reset masks every enable and select in the same cycle
  always_comb begin
    InstWrite = reset && (cur == FETCH) && last;
    PCWrite   = reset && (((cur == FETCH) && last) ||
                ((cur == EXEC) && ((op == 4'd5) || (op == 4'd6) || (op == 4'd7) || ((op == 4'd8) && comp_true))));
    PCSrc     = (!reset || cur != EXEC) ? 3'd0 :
                (op == 4'd5) ? 3'd1 :
                (op == 4'd6) ? 3'd3 :
                (op == 4'd7) ? 3'd2 :
                (op == 4'd8) ? 3'd4 : 3'd0;
    MemSrc    = !reset ? 2'd0 :
                (cur == MEMRD) ? ((op == 4'd4) ? 2'd1 : 2'd2) :
                (cur == MEMWR) ? ((op == 4'd3) ? 2'd1 : 2'd2) : 2'd0;
    MemWrite  = reset && (cur == MEMWR) && last;
    MemDst    = 3'd0;
    SPWrite   = reset && (cur == SPADJ);
    SPSrc     = (reset && (cur == SPADJ) && (op == 4'd4)) ? 3'd1 : 3'd0;
    RegWrite  = reset && (cur == WB);
    RegWSel   = 2'd0;
    AluWrite  = reset && (cur == EXEC) && (op == 4'd0);
    illegal   = reset && (cur == DECODE) && bad_op;
    halted    = cur == HALT;
    state     = cur;
  end
endmodule

// File: tb/tb_mem_control_fsm.sv
// tb_mem_control_fsm: directed vector table plus multi-cycle wait/reset sequences for mem_control_fsm
module tb_mem_control_fsm;
  localparam int FE = 0, DE = 1, EX = 2, MR = 3, MW = 4, WB = 5, SA = 6, HL = 7;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic rst0, rst1, comp0, comp1;
  logic [15:0] inst0, inst1;
  logic mw0, pcw0, spw0, iw0, rw0, aw0, h0, il0;
  logic [1:0] ms0, rs0;
  logic [2:0] md0, ps0, ss0, st0;
  logic mw1, pcw1, spw1, iw1, rw1, aw1, h1, il1;
  logic [1:0] ms1, rs1;
  logic [2:0] md1, ps1, ss1, st1;
  logic [23:0] a0, a1;
  mem_control_fsm #(.MEM_WAIT(0)) dut0 (
    .clock(clk), .reset(rst0), .inst(inst0), .comp_true(comp0),
    .MemWrite(mw0), .MemSrc(ms0), .MemDst(md0), .PCSrc(ps0), .SPSrc(ss0),
    .PCWrite(pcw0), .SPWrite(spw0), .InstWrite(iw0), .RegWrite(rw0), .RegWSel(rs0),
    .AluWrite(aw0), .halted(h0), .illegal(il0), .state(st0)
  );
  mem_control_fsm #(.MEM_WAIT(3)) dut1 (
    .clock(clk), .reset(rst1), .inst(inst1), .comp_true(comp1),
    .MemWrite(mw1), .MemSrc(ms1), .MemDst(md1), .PCSrc(ps1), .SPSrc(ss1),
    .PCWrite(pcw1), .SPWrite(spw1), .InstWrite(iw1), .RegWrite(rw1), .RegWSel(rs1),
    .AluWrite(aw1), .halted(h1), .illegal(il1), .state(st1)
  );
  assign a0 = {st0, mw0, ms0, pcw0, ps0, spw0, ss0, iw0, rw0, rs0, md0, aw0, h0, il0};
  assign a1 = {st1, mw1, ms1, pcw1, ps1, spw1, ss1, iw1, rw1, rs1, md1, aw1, h1, il1};
  function automatic logic [23:0] ex(int st, int mw, int ms, int pw, int ps, int sw, int ss,
                                     int iw, int rw, int aw, int h, int il);
    return {3'(st), 1'(mw), 2'(ms), 1'(pw), 3'(ps), 1'(sw), 3'(ss), 1'(iw), 1'(rw),
            2'b00, 3'b000, 1'(aw), 1'(h), 1'(il)};
  endfunction
  typedef struct {
    logic        rst;
    logic [15:0] inst;
    logic        comp;
    logic [23:0] e;
  } vec_t;
  vec_t v[$];
  task automatic chk(string nm, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic add(logic r, logic [15:0] i, logic c, logic [23:0] e);
    vec_t t;
    t.rst = r; t.inst = i; t.comp = c; t.e = e;
    v.push_back(t);
  endtask
  task automatic step1(string nm, logic r, logic [15:0] i, logic [23:0] e);
    @(negedge clk);
    rst1 = r; inst1 = i;
    #1 chk(nm, a1, e);
  endtask
  initial begin
    logic [23:0] f, fw, d, z;
    f  = ex(FE, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    fw = ex(FE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    d  = ex(DE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z  = fw;
    add(0, 16'h0000, 0, z);
    add(1, 16'h0000, 0, f); add(1, 16'h0000, 0, d);
    add(1, 16'h0000, 0, ex(EX, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(1, 16'h3000, 0, f); add(1, 16'h3000, 0, d);
    add(1, 16'h3000, 0, ex(SA, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(1, 16'h3000, 0, ex(MW, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h4000, 0, f); add(1, 16'h4000, 0, d);
    add(1, 16'h4000, 0, ex(MR, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h4000, 0, ex(WB, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(1, 16'h4000, 0, ex(SA, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    add(1, 16'h8000, 0, f); add(1, 16'h8000, 0, d);
    add(1, 16'h8000, 0, ex(EX, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h8000, 1, f); add(1, 16'h8000, 1, d);
    add(1, 16'h8000, 1, ex(EX, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h1234, 0, f); add(1, 16'h1234, 0, d);
    add(1, 16'h1234, 0, ex(MR, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h1234, 0, ex(WB, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(1, 16'h2000, 0, f); add(1, 16'h2000, 0, d);
    add(1, 16'h2000, 0, ex(MW, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h5000, 0, f); add(1, 16'h5000, 0, d);
    add(1, 16'h5000, 0, ex(EX, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h6000, 0, f); add(1, 16'h6000, 0, d);
    add(1, 16'h6000, 0, ex(EX, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'h7000, 1, f); add(1, 16'h7000, 1, d);
    add(1, 16'h7000, 1, ex(EX, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    add(1, 16'hA000, 0, f);
    add(1, 16'hA000, 0, ex(DE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 16'hE000, 0, f);
    add(1, 16'hE000, 0, ex(DE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 16'hF000, 0, f); add(1, 16'hF000, 0, d);
    add(1, 16'hF000, 0, ex(HL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    rst0 = 1'b0; rst1 = 1'b0; comp0 = 1'b0; comp1 = 1'b0;
    inst0 = 16'h0000; inst1 = 16'h0000;
    repeat (2) @(posedge clk);
    foreach (v[i]) begin
      @(negedge clk);
      rst0 = v[i].rst; inst0 = v[i].inst; comp0 = v[i].comp;
      #1 chk($sformatf("vec%0d_op%h", i, v[i].inst[15:12]), a0, v[i].e);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      comp0 = k[0];
      inst0 = (k > 10) ? 16'h0000 : 16'hF000;
      #1 chk($sformatf("halt_hold%0d", k), a0, ex(HL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    @(negedge clk);
    rst0 = 1'b0; inst0 = 16'h0000;
    @(negedge clk);
    rst0 = 1'b1;
    #1 chk("halt_reset_clear", a0, f);
    for (int k = 0; k < 3; k++) step1($sformatf("w3_fetch_wait%0d", k), 1, 16'h2000, fw);
    step1("w3_fetch_commit", 1, 16'h2000, f);
    step1("w3_decode", 1, 16'h2000, d);
    for (int k = 0; k < 3; k++)
      step1($sformatf("w3_memwr_wait%0d", k), 1, 16'h2000, ex(MW, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step1("w3_memwr_strobe", 1, 16'h2000, ex(MW, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) step1($sformatf("w3_refetch_wait%0d", k), 1, 16'h2000, fw);
    step1("w3_refetch_commit", 1, 16'h2000, f);
    step1("w3_decode2", 1, 16'h2000, d);
    step1("w3_memwr_c1", 1, 16'h2000, ex(MW, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step1("w3_memwr_reset", 0, 16'h2000, ex(MW, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) step1($sformatf("w3_after_reset_wait%0d", k), 1, 16'h2000, fw);
    step1("w3_after_reset_commit", 1, 16'h2000, f);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
